// File: rtl/dom_rnd_source.sv
// dom_rnd_source: seeded 64-bit LFSR producing per-cycle Z (remask) and B (blinding)
// randomness for DOM multipliers, with seed load, warm-up and reseed request.
module dom_rnd_source #(
   parameter int SHARES = 2,
   parameter int FIRST_ORDER_OPTIMIZATION = 1,
   parameter int WARMUP_CYCLES = 16,
   parameter int RESEED_INTERVAL = 4096,
   localparam int ZW = 2*SHARES*(SHARES-1),
   localparam int BN = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 1 : SHARES,
   localparam int BW = 4*BN
) (
   input  logic          ClkxCI,
   input  logic          RstxBI,
   input  logic [31:0]   SeedxDI,
   input  logic          SeedValidxSI,
   output logic          SeedReadyxSO,
   output logic [ZW-1:0] _ZxDO,
   output logic [BW-1:0] _BxDO,
   output logic          RndValidxSO,
   input  logic          RndReadyxSI,
   output logic          ReseedReqxSO
);
   localparam int RW = ZW+BW;
   localparam int WCW = $clog2(WARMUP_CYCLES+1);
   localparam int CW = $clog2(RESEED_INTERVAL+1);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WARMUP = 2'd2, RUN = 2'd3;

   logic [1:0]     state;
   logic [63:0]    lfsr, lfsr_adv, seed_full;
   logic [31:0]    seed_lo;
   logic [RW-1:0]  w;
   logic [WCW-1:0] warm_cnt;
   logic [CW-1:0]  word_cnt;
   logic           seed_hs, xfer;

   assign SeedReadyxSO = RstxBI && state != WARMUP;
   assign RndValidxSO = state == RUN;
   assign seed_hs = SeedValidxSI && SeedReadyxSO;
   assign xfer = RndValidxSO && RndReadyxSI;
   assign seed_full = {SeedxDI, seed_lo};

   // RW unrolled steps; the first generated bit lands at the word MSB
   always_comb begin
      lfsr_adv = lfsr;
      w = '0;
      for (int i = 0; i < RW; i++) begin
         lfsr_adv = {lfsr_adv[62:0], lfsr_adv[63] ^ lfsr_adv[62] ^ lfsr_adv[60] ^ lfsr_adv[59]};
         w[RW-1-i] = lfsr_adv[0];
      end
   end

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         state <= IDLE;
         lfsr <= '0;
         seed_lo <= '0;
         _ZxDO <= '0;
         _BxDO <= '0;
         warm_cnt <= '0;
         word_cnt <= '0;
         ReseedReqxSO <= 1'b0;
      end else begin
         if (xfer || state == WARMUP)
            lfsr <= lfsr_adv;
         if (xfer) begin
            {_ZxDO, _BxDO} <= w;
            word_cnt <= (word_cnt == CW'(RESEED_INTERVAL)) ? word_cnt : word_cnt + 1'b1;
            if (word_cnt == CW'(RESEED_INTERVAL-1))
               ReseedReqxSO <= 1'b1;
         end
         if (state == WARMUP) begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WCW'(WARMUP_CYCLES-1)) begin
               {_ZxDO, _BxDO} <= w;
               state <= RUN;
            end
         end
         // an all-zero seed would lock the LFSR, so substitute 1
         if (seed_hs && state == LOAD) begin
            lfsr <= (seed_full == 64'd0) ? 64'd1 : seed_full;
            warm_cnt <= '0;
            word_cnt <= '0;
            ReseedReqxSO <= 1'b0;
            state <= WARMUP;
         end else if (seed_hs) begin
            seed_lo <= SeedxDI;
            state <= LOAD;
         end
      end
   end
endmodule

// File: tb/tb_dom_rnd_source.sv
// tb_dom_rnd_source: bit-stream model of the LFSR checked every cycle against
// SHARES=2 and SHARES=3 instances driven by identical directed stimulus.
module tb_dom_rnd_source;
   localparam int W = 16, RI = 8;

   logic        clk = 0, rst_n = 0, seed_valid = 0, rnd_ready = 0;
   logic [31:0] seed = '0;
   logic        sr2, sr3, v2, v3, rq2, rq3;
   logic [3:0]  z2, b2;
   logic [11:0] z3, b3;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   dom_rnd_source #(.SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .WARMUP_CYCLES(W), .RESEED_INTERVAL(RI)) u_s2 (
      .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_valid), .SeedReadyxSO(sr2),
      ._ZxDO(z2), ._BxDO(b2), .RndValidxSO(v2), .RndReadyxSI(rnd_ready), .ReseedReqxSO(rq2));

   dom_rnd_source #(.SHARES(3), .FIRST_ORDER_OPTIMIZATION(1), .WARMUP_CYCLES(W), .RESEED_INTERVAL(RI)) u_s3 (
      .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_valid), .SeedReadyxSO(sr3),
      ._ZxDO(z3), ._BxDO(b3), .RndValidxSO(v3), .RndReadyxSI(rnd_ready), .ReseedReqxSO(rq3));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // the LFSR as a bit stream: b[k] = b[k-64]^b[k-63]^b[k-61]^b[k-60], b[0..63] = seed MSB..LSB
   function automatic logic [63:0] model_word(input logic [63:0] s, input int rw, input int idx);
      bit b [0:16383];
      logic [63:0] r;
      int base;
      r = '0;
      base = 64 + rw*idx;
      for (int k = 0; k < 64; k++) b[k] = s[63-k];
      for (int k = 64; k < base+rw; k++) b[k] = b[k-64] ^ b[k-63] ^ b[k-61] ^ b[k-60];
      for (int t = 0; t < rw; t++) r[rw-1-t] = b[base+t];
      return r;
   endfunction

   logic [31:0] m_lo;
   logic [63:0] m_seed;
   logic [63:0] m_word [2];
   int          m_warm, m_adv, m_cnt;
   bit          m_load, m_run, m_req;
   int          rws [2] = '{8, 24};

   always @(negedge clk) begin
      logic [63:0] act [2];
      act[0] = {56'd0, z2, b2};
      act[1] = {40'd0, z3, b3};
      if (!rst_n) begin
         m_lo = '0; m_seed = '0; m_warm = 0; m_adv = 0; m_cnt = 0;
         m_load = 0; m_run = 0; m_req = 0; m_word[0] = '0; m_word[1] = '0;
      end
      chk("seed_ready_s2", sr2, rst_n && m_warm == 0);
      chk("seed_ready_s3", sr3, rst_n && m_warm == 0);
      chk("valid_s2", v2, m_run);
      chk("valid_s3", v3, m_run);
      chk("reseed_req_s2", rq2, m_req);
      chk("reseed_req_s3", rq3, m_req);
      chk("word_s2", act[0], m_word[0]);
      chk("word_s3", act[1], m_word[1]);
      if (rst_n) begin
         if (m_run && rnd_ready) begin
            for (int i = 0; i < 2; i++) m_word[i] = model_word(m_seed, rws[i], m_adv);
            m_adv++;
            if (m_cnt < RI) m_cnt++;
            if (m_cnt == RI) m_req = 1;
         end
         if (m_warm > 0) begin
            m_warm--;
            if (m_warm == 0) begin
               for (int i = 0; i < 2; i++) m_word[i] = model_word(m_seed, rws[i], W-1);
               m_adv = W;
               m_run = 1;
            end
         end else if (seed_valid) begin
            if (m_load) begin
               m_seed = ({seed, m_lo} == 64'd0) ? 64'd1 : {seed, m_lo};
               m_warm = W; m_adv = 0; m_cnt = 0; m_req = 0; m_load = 0;
            end else begin
               m_lo = seed; m_load = 1; m_run = 0;
            end
         end
      end
   end

   task automatic send_beat(input logic [31:0] d);
      int n;
      bit ok;
      n = 0;
      seed = d;
      seed_valid = 1;
      do begin
         @(negedge clk);
         ok = sr2;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 100);
      seed_valid = 0;
      chk("seed_beat_accepted", ok, 1);
   endtask

   task automatic wait_valid(input int exp);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!v2 && n < 100);
      chk("valid_latency", n, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      bit nz;
      int pat [4] = '{1, 0, 0, 1};
      chk("pin_seed1_w8_idx0", model_word(64'd1, 8, 0), 64'h0);
      chk("pin_seed1_w8_idx7", model_word(64'd1, 8, 7), 64'h1B);
      chk("pin_seed1_w24_idx2", model_word(64'd1, 24, 2), 64'h1B00);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", v2, 0);
      chk("rst_seed_ready", sr2, 0);
      chk("rst_words", {z2, b2, z3, b3}, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_seed_ready", sr2, 1);
      chk("post_rst_valid", v2, 0);
      @(posedge clk);
      #1;
      // first seed, no backpressure, reseed request after 8 transfers
      rnd_ready = 1;
      send_beat(32'h89ABCDEF);
      send_beat(32'h01234567);
      wait_valid(W+1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rq2 && k < 50);
      chk("req_after_transfers", k, RI);
      repeat (92) @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         rnd_ready = pat[i%4][0];
         @(posedge clk);
         #1;
      end
      rnd_ready = 1;
      // reseed while running, beat coincides with a transfer
      send_beat(32'hDEADBEEF);
      @(negedge clk);
      chk("valid_drop_after_first_beat", v2, 0);
      chk("req_held_in_load", rq2, 1);
      @(posedge clk);
      #1;
      send_beat(32'hCAFEF00D);
      @(negedge clk);
      chk("req_cleared", rq2, 0);
      wait_valid(W);
      repeat (60) @(posedge clk);
      #1;
      // zero seed falls back to 64'h1
      send_beat(32'h0);
      send_beat(32'h0);
      wait_valid(W+1);
      nz = 0;
      repeat (100) begin
         @(negedge clk);
         if (v2 && {z2, b2} != 8'h0) nz = 1;
      end
      chk("zero_seed_nonzero_output", nz, 1);
      @(posedge clk);
      #1;
      // reset during warm-up
      send_beat(32'h11111111);
      send_beat(32'h22222222);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      chk("midrst_valid", v2, 0);
      chk("midrst_seed_ready", sr2, 0);
      chk("midrst_req", rq2, 0);
      chk("midrst_words", {z2, b2, z3, b3}, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      send_beat(32'h33333333);
      repeat (30) @(negedge clk);
      chk("single_beat_no_valid", v2, 0);
      // reset between beats discards the stored low word
      @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      send_beat(32'h44444444);
      send_beat(32'h55555555);
      wait_valid(W+1);
      repeat (30) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dom_rnd_source.md
Name: dom_rnd_source

Overview:
- Fresh-randomness producer for the DOM shared GF(4)/GF(16) multipliers and the masked S-box.
- Supplies the per-cycle remask bits (Z) and blinding bits (B) those multipliers consume, sized from the same SHARES and FIRST_ORDER_OPTIMIZATION parameters.
- Internally a seeded 64-bit LFSR with leap-forward stepping, a seed-load/warm-up state machine, a valid/ready output handshake and a reseed-request counter.

Parameters:
- SHARES, 2, number of shares; legal 2..4.
- FIRST_ORDER_OPTIMIZATION, 1, 1 selects the reduced blinding width when SHARES==2.
- WARMUP_CYCLES, 16, LFSR advance cycles after seeding before output is valid; minimum 1.
- RESEED_INTERVAL, 4096, number of delivered words after which a reseed is requested; minimum 1.

Derived constants:
- ZW = 2*SHARES*(SHARES-1).
- BN = 1 if (FIRST_ORDER_OPTIMIZATION==1 && SHARES==2), else SHARES.
- BW = 4*BN.
- RW = ZW+BW; RW<=64 is guaranteed by the legal range.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedxDI  in  32  seed beat; low word first, then high word.
- SeedValidxSI  in  1  seed beat valid.
- SeedReadyxSO  out  1  seed beat accepted when high together with SeedValidxSI.
- _ZxDO  out  ZW  remask randomness, same bit layout as multiplier _ZxDI.
- _BxDO  out  BW  blinding randomness, same bit layout as multiplier _BxDI.
- RndValidxSO  out  1  Z/B word valid.
- RndReadyxSI  in  1  consumer takes current word.
- ReseedReqxSO  out  1  sticky reseed request.

Behaviour:

Reset:
- Asynchronous: state=IDLE; LFSR, seed-low register, Z, B and all counters = 0.
- RndValidxSO=0, ReseedReqxSO=0.
- Reset mid-operation aborts any seed load or warm-up and discards the current word.

LFSR:
- 64-bit Fibonacci LFSR, polynomial x^64+x^63+x^61+x^60+1.
- One step: new = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], new}.
- One "advance" = RW steps, unrolled combinationally.
- The RW new bits, first-generated at the MSB, form word W = {Z, B}: Z = W[RW-1:BW], B = W[BW-1:0].

States:
- IDLE:
  - SeedReadyxSO=1.
  - A seed beat handshake stores the low word -> LOAD.
- LOAD:
  - SeedReadyxSO=1.
  - A handshake loads LFSR <= {SeedxDI, low}.
  - If that value is all-zero, load 64'h0000_0000_0000_0001 instead.
  - Clear the warm-up counter and the word counter, clear ReseedReqxSO -> WARMUP.
- WARMUP:
  - SeedReadyxSO=0, RndValidxSO=0.
  - LFSR advances every cycle for WARMUP_CYCLES cycles.
  - On the last of these cycles, the Z/B registers capture that advance's W -> RUN.
  - If the second seed beat is accepted in cycle t, RndValidxSO=1 from cycle t+WARMUP_CYCLES+1.
- RUN:
  - RndValidxSO=1, SeedReadyxSO=1.
  - If RndReadyxSI=1: Z/B <= next W, LFSR advances, word counter increments.
  - If RndReadyxSI=0: Z, B and LFSR hold unchanged.
  - A seed beat handshake in RUN stores the low word -> LOAD. RndValidxSO=0 from the next cycle.
  - If RndReadyxSI and a seed handshake coincide, the word transfer completes and the seed handshake takes priority for the state change.

Outputs outside RUN:
- Z/B keep their last value; consumers qualify them with RndValidxSO.
- No word is ever delivered twice: consumed words are never re-presented.

Reseed request:
- Word counter saturates at RESEED_INTERVAL.
- ReseedReqxSO is set on the cycle the counter reaches RESEED_INTERVAL and stays set until the LOAD->WARMUP transition.
- Output continues while the request is pending.

Test Plan:
- Reset values: hold RstxBI=0 mid-clock -> all outputs 0 immediately. Release -> SeedReadyxSO=1, RndValidxSO=0.
- Seed latency and sequence:
  - Beats 32'h89ABCDEF then 32'h01234567 with WARMUP_CYCLES=16 -> RndValidxSO rises exactly 17 cycles after the second handshake.
  - With RndReadyxSI=1, 100 consecutive {Z, B} words match a bit-exact software LFSR model for SHARES=2 (RW=8) and SHARES=3 (RW=24).
- Zero seed: beats 0, 0 -> output matches the model seeded with 64'h1; output is never stuck at all-zero.
- Backpressure: RndReadyxSI toggled 1,0,0,1 -> Z/B stable during the 0 cycles; word sequence identical to the no-stall run; no skipped or repeated words.
- Reseed and request:
  - RESEED_INTERVAL=8 -> ReseedReqxSO rises on the 8th transfer.
  - Seed beats in RUN -> RndValidxSO falls the cycle after the first beat; ReseedReqxSO clears on second-beat acceptance; new sequence matches the model for the new seed.
- Reset mid-operation: assert RstxBI during WARMUP, and separately between the two seed beats -> return to IDLE; a fresh two-beat seed is required; the stored low beat is not reused.
